// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Handshake bus between the arbiter and the single-ported,
//                long-latency main memory (enable / requestComplete).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
  parameter int ADDR_LENGTH = 10,
  parameter int BLOCK_SIZE  = 32
);
  logic                   mem_enable;
  logic                   mem_we;
  logic [ADDR_LENGTH-1:0] mem_addr;
  logic [BLOCK_SIZE-1:0]  mem_wdata;
  logic [BLOCK_SIZE-1:0]  mem_rdata;
  logic                   mem_complete;

  // Arbiter side: drives the access, receives data and completion
  modport master (
    output mem_enable, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_complete
  );

  // Memory side
  modport slave (
    input  mem_enable, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_complete
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-port round-robin arbiter and sequencer in front of a
//                single-ported, long-latency memory. Serialises block
//                read/write requests onto the enable/complete handshake and
//                aborts accesses the memory never completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_LENGTH = 10,
  parameter int BLOCK_SIZE  = 32,
  parameter int TIMEOUT     = 255
) (
  input  wire                    clk,
  input  wire                    reset,
  input  wire                    i_req0,
  input  wire                    i_req1,
  input  wire                    i_we0,
  input  wire                    i_we1,
  input  wire [ADDR_LENGTH-1:0]  i_addr0,
  input  wire [ADDR_LENGTH-1:0]  i_addr1,
  input  wire [BLOCK_SIZE-1:0]   i_wdata0,
  input  wire [BLOCK_SIZE-1:0]   i_wdata1,
  output logic                   o_done0,
  output logic                   o_done1,
  output logic [BLOCK_SIZE-1:0]  o_rdata,
  output logic                   o_busy,
  output logic                   o_err,
  mem_arbiter_if.master          mem_bus
);

  // Watchdog counter is sized to hold TIMEOUT itself
  localparam int c_CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t                 r_state,      w_state;
  logic                   r_last_grant, w_last_grant;
  logic                   r_grant,      w_grant;
  logic [c_CNT_W-1:0]     r_cnt,        w_cnt;
  logic [BLOCK_SIZE-1:0]  r_rdata,      w_rdata;
  logic                   r_err,        w_err;
  logic                   r_done0,      w_done0;
  logic                   r_done1,      w_done1;
  logic                   r_mem_enable, w_mem_enable;
  logic                   r_mem_we,     w_mem_we;
  logic [ADDR_LENGTH-1:0] r_mem_addr,   w_mem_addr;
  logic [BLOCK_SIZE-1:0]  r_mem_wdata,  w_mem_wdata;
  logic                   w_sel;

  // State and datapath registers; reset abandons any in-flight access
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_cnt        <= '0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
      r_mem_enable <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_state      <= w_state;
      r_last_grant <= w_last_grant;
      r_grant      <= w_grant;
      r_cnt        <= w_cnt;
      r_rdata      <= w_rdata;
      r_err        <= w_err;
      r_done0      <= w_done0;
      r_done1      <= w_done1;
      r_mem_enable <= w_mem_enable;
      r_mem_we     <= w_mem_we;
      r_mem_addr   <= w_mem_addr;
      r_mem_wdata  <= w_mem_wdata;
    end
  end

  // Next-state: round-robin grant in IDLE, completion/watchdog in ACCESS
  always_comb begin
    w_state      = r_state;
    w_last_grant = r_last_grant;
    w_grant      = r_grant;
    w_cnt        = r_cnt;
    w_rdata      = r_rdata;
    w_err        = r_err;
    w_done0      = 1'b0;
    w_done1      = 1'b0;
    w_mem_enable = r_mem_enable;
    w_mem_we     = r_mem_we;
    w_mem_addr   = r_mem_addr;
    w_mem_wdata  = r_mem_wdata;
    w_sel        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_req0 || i_req1) begin
          // On a tie the requester not served last wins
          w_sel        = (i_req0 && i_req1) ? ~r_last_grant : i_req1;
          w_grant      = w_sel;
          w_last_grant = w_sel;
          w_mem_we     = w_sel ? i_we1    : i_we0;
          w_mem_addr   = w_sel ? i_addr1  : i_addr0;
          w_mem_wdata  = w_sel ? i_wdata1 : i_wdata0;
          w_mem_enable = 1'b1;
          w_cnt        = '0;
          w_state      = S_ACCESS;
        end
      end

      S_ACCESS: begin
        // A zero count marks the first ACCESS cycle, where a complete left
        // over from the previous access must not be believed
        if ((r_cnt != '0) && mem_bus.mem_complete) begin
          w_rdata      = mem_bus.mem_rdata;
          w_mem_enable = 1'b0;
          w_done0      = ~r_grant;
          w_done1      = r_grant;
          w_state      = S_RELEASE;
        end else if (r_cnt == c_TIMEOUT) begin
          w_rdata      = '0;
          w_err        = 1'b1;
          w_mem_enable = 1'b0;
          w_done0      = ~r_grant;
          w_done1      = r_grant;
          w_state      = S_RELEASE;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      S_RELEASE: begin
        // One low-enable cycle so the next access sees a fresh rising edge
        w_state = S_IDLE;
      end

      default: begin
        w_mem_enable = 1'b0;
        w_state      = S_IDLE;
      end
    endcase
  end

  assign o_done0  = r_done0;
  assign o_done1  = r_done1;
  assign o_rdata  = r_rdata;
  assign o_err    = r_err;
  assign o_busy   = (r_state != S_IDLE);

  assign mem_bus.mem_enable = r_mem_enable;
  assign mem_bus.mem_we     = r_mem_we;
  assign mem_bus.mem_addr   = r_mem_addr;
  assign mem_bus.mem_wdata  = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed self-checking bench for mem_arbiter with a simple
//                fixed-delay memory model (each word initialised to its index).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int AW    = 10;
  localparam int BW    = 32;
  localparam int TMO   = 20;
  localparam int DELAY = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic          we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [BW-1:0] wdata0 = '0, wdata1 = '0;
  logic          done0, done1, busy, err;
  logic [BW-1:0] rdata;

  int errors = 0;
  int checks = 0;

  mem_arbiter_if #(.ADDR_LENGTH(AW), .BLOCK_SIZE(BW)) mem_if ();

  mem_arbiter #(.ADDR_LENGTH(AW), .BLOCK_SIZE(BW), .TIMEOUT(TMO)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_req0   (req0),
    .i_req1   (req1),
    .i_we0    (we0),
    .i_we1    (we1),
    .i_addr0  (addr0),
    .i_addr1  (addr1),
    .i_wdata0 (wdata0),
    .i_wdata1 (wdata1),
    .o_done0  (done0),
    .o_done1  (done1),
    .o_rdata  (rdata),
    .o_busy   (busy),
    .o_err    (err),
    .mem_bus  (mem_if)
  );

  always #5 clk = ~clk;

  // Memory model: completes DELAY cycles after enable rises, returns the
  // pre-write contents, holds complete until enable drops
  logic [BW-1:0] mem [0:1023];
  bit            m_inited = 1'b0;
  int            m_cnt = 0;
  bit            m_done = 1'b0;
  logic          m_complete = 1'b0;
  logic [BW-1:0] m_rdata = '0;
  bit            never_complete = 1'b0;
  logic          stale_force = 1'b0;

  always @(posedge clk) begin
    if (!m_inited) begin
      for (int i = 0; i < 1024; i++) mem[i] <= BW'(i);
      m_inited <= 1'b1;
    end
    if (!mem_if.mem_enable) begin
      m_cnt      <= 0;
      m_done     <= 1'b0;
      m_complete <= 1'b0;
    end else begin
      m_cnt <= m_cnt + 1;
      if (!m_done && !never_complete && m_cnt == DELAY - 1) begin
        m_complete <= 1'b1;
        m_done     <= 1'b1;
        m_rdata    <= mem[mem_if.mem_addr];
        if (mem_if.mem_we) mem[mem_if.mem_addr] <= mem_if.mem_wdata;
      end
    end
  end

  assign mem_if.mem_rdata    = m_rdata;
  assign mem_if.mem_complete = m_complete | stale_force;

  // One request from one port; observes latency (cycles from the IDLE
  // request cycle), captured rdata, done pulses and enable rising edges
  task automatic single_req(input bit port, input bit we, input logic [AW-1:0] a,
                            input logic [BW-1:0] wd, input bit stale,
                            output logic [BW-1:0] rd, output int lat,
                            output int nown, output int noth, output int nrise,
                            output bit b_rel, output bit b_idle);
    bit prev_en;
    bit seen;
    rd = '0; lat = -1; nown = 0; noth = 0; nrise = 0; b_rel = 1'b0; b_idle = 1'b1; seen = 1'b0;
    @(negedge clk);
    prev_en = mem_if.mem_enable;
    if (port == 1'b0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd; end
    else              begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd; end
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (stale && c == 1) stale_force = 1'b1;
      if (c == 2) stale_force = 1'b0;
      if (mem_if.mem_enable && !prev_en) nrise++;
      prev_en = mem_if.mem_enable;
      if ((port == 1'b0) ? done0 : done1) begin
        nown++;
        if (!seen) begin
          seen = 1'b1; lat = c; rd = rdata; b_rel = busy;
          if (port == 1'b0) req0 = 1'b0; else req1 = 1'b0;
        end
      end
      if ((port == 1'b0) ? done1 : done0) noth++;
      if (seen && c == lat + 1) b_idle = busy;
      if (seen && c >= lat + 3) break;
    end
    req0 = 1'b0; req1 = 1'b0; stale_force = 1'b0;
  endtask

  // Both ports read at once; reports which was served first
  task automatic run_pair(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          output int first, output logic [BW-1:0] rd0,
                          output logic [BW-1:0] rd1, output int overlap);
    bit s0, s1;
    first = -1; rd0 = '0; rd1 = '0; overlap = 0; s0 = 1'b0; s1 = 1'b0;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = a0;
    req1 = 1'b1; we1 = 1'b0; addr1 = a1;
    reset = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done0 && done1) overlap++;
      if (done0 && !s0) begin s0 = 1'b1; rd0 = rdata; req0 = 1'b0; if (first < 0) first = 0; end
      if (done1 && !s1) begin s1 = 1'b1; rd1 = rdata; req1 = 1'b0; if (first < 0) first = 1; end
      if (s0 && s1) break;
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({done0, done1, busy, err, mem_if.mem_enable, mem_if.mem_we} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {done0, done1, busy, err, mem_if.mem_enable, mem_if.mem_we});
    end
    checks++;
    if (rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    checks++;
    if (mem_if.mem_addr !== '0 || mem_if.mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_membus: addr %h wdata %h expected 0", mem_if.mem_addr, mem_if.mem_wdata);
    end
  endtask

  task automatic test_simultaneous();
    int first, ov;
    logic [BW-1:0] r0, r1;
    run_pair(10'd5, 10'd7, first, r0, r1, ov);
    checks++;
    if (first !== 0) begin errors++; $display("FAIL tie_first: got %0d expected 0", first); end
    checks++;
    if (r0 !== 32'd5) begin errors++; $display("FAIL tie_rdata0: got %h expected 5", r0); end
    checks++;
    if (r1 !== 32'd7) begin errors++; $display("FAIL tie_rdata1: got %h expected 7", r1); end
    checks++;
    if (ov !== 0) begin errors++; $display("FAIL tie_overlap: got %0d expected 0", ov); end
  endtask

  task automatic test_single_read();
    logic [BW-1:0] rd;
    int lat, nown, noth, nrise;
    bit brel, bidle;
    single_req(1'b0, 1'b0, 10'd10, '0, 1'b0, rd, lat, nown, noth, nrise, brel, bidle);
    checks++;
    if (rd !== 32'd10) begin errors++; $display("FAIL single_rdata: got %h expected a", rd); end
    checks++;
    if (lat !== DELAY + 2) begin errors++; $display("FAIL single_latency: got %0d expected %0d", lat, DELAY + 2); end
    checks++;
    if (nown !== 1 || noth !== 0) begin
      errors++; $display("FAIL single_done_count: done0 %0d done1 %0d expected 1 and 0", nown, noth);
    end
    checks++;
    if (nrise !== 1) begin errors++; $display("FAIL single_enable_rises: got %0d expected 1", nrise); end
    checks++;
    if (brel !== 1'b1 || bidle !== 1'b0) begin
      errors++; $display("FAIL single_busy: release %b idle %b expected 1 and 0", brel, bidle);
    end
  endtask

  task automatic test_second_tie();
    int first, ov;
    logic [BW-1:0] r0, r1;
    run_pair(10'd5, 10'd7, first, r0, r1, ov);
    checks++;
    if (first !== 1) begin errors++; $display("FAIL tie2_first: got %0d expected 1", first); end
    checks++;
    if (r0 !== 32'd5 || r1 !== 32'd7) begin
      errors++; $display("FAIL tie2_rdata: got %h/%h expected 5/7", r0, r1);
    end
  endtask

  task automatic test_write_read();
    logic [BW-1:0] rd;
    int lat, nown, noth, nrise;
    bit brel, bidle;
    single_req(1'b1, 1'b1, 10'd50, 32'hDEADBEEF, 1'b0, rd, lat, nown, noth, nrise, brel, bidle);
    checks++;
    if (rd !== 32'd50 || nown !== 1) begin
      errors++; $display("FAIL write_old_data: got %h (done1 x%0d) expected 32 (x1)", rd, nown);
    end
    single_req(1'b0, 1'b0, 10'd50, '0, 1'b0, rd, lat, nown, noth, nrise, brel, bidle);
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL read_back: got %h expected deadbeef", rd); end
  endtask

  task automatic test_stale_complete();
    logic [BW-1:0] rd;
    int lat, nown, noth, nrise;
    bit brel, bidle;
    single_req(1'b0, 1'b0, 10'd20, '0, 1'b1, rd, lat, nown, noth, nrise, brel, bidle);
    checks++;
    if (lat !== DELAY + 2 || nown !== 1) begin
      errors++; $display("FAIL stale_latency: got %0d (x%0d) expected %0d (x1)", lat, nown, DELAY + 2);
    end
    checks++;
    if (rd !== 32'd20) begin errors++; $display("FAIL stale_rdata: got %h expected 14", rd); end
  endtask

  task automatic test_timeout();
    logic [BW-1:0] rd;
    int lat, nown, noth, nrise;
    bit brel, bidle;
    never_complete = 1'b1;
    single_req(1'b0, 1'b0, 10'd3, '0, 1'b0, rd, lat, nown, noth, nrise, brel, bidle);
    never_complete = 1'b0;
    checks++;
    if (lat !== TMO + 2 || nown !== 1) begin
      errors++; $display("FAIL timeout_latency: got %0d (x%0d) expected %0d (x1)", lat, nown, TMO + 2);
    end
    checks++;
    if (rd !== '0) begin errors++; $display("FAIL timeout_rdata: got %h expected 0", rd); end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b expected 1", err); end
    single_req(1'b1, 1'b0, 10'd9, '0, 1'b0, rd, lat, nown, noth, nrise, brel, bidle);
    checks++;
    if (rd !== 32'd9 || lat !== DELAY + 2) begin
      errors++; $display("FAIL after_timeout: rdata %h lat %0d expected 9 and %0d", rd, lat, DELAY + 2);
    end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err); end
  endtask

  task automatic test_reset_mid_access();
    int n, first, ov;
    logic [BW-1:0] r0, r1;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'd30;
    repeat (4) @(negedge clk);
    checks++;
    if (mem_if.mem_enable !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL pre_reset_access: enable %b busy %b expected 1 1", mem_if.mem_enable, busy);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_if.mem_enable, busy, err, done0, done1} !== 5'b0) begin
      errors++; $display("FAIL mid_reset_state: got %b expected 00000",
                         {mem_if.mem_enable, busy, err, done0, done1});
    end
    reset = 1'b0; req0 = 1'b0;
    n = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done0 || done1 || mem_if.mem_enable) n++;
    end
    checks++;
    if (n !== 0) begin errors++; $display("FAIL post_reset_quiet: got %0d active cycles expected 0", n); end
    run_pair(10'd5, 10'd7, first, r0, r1, ov);
    checks++;
    if (first !== 0 || r0 !== 32'd5 || r1 !== 32'd7) begin
      errors++; $display("FAIL post_reset_tie: first %0d rdata %h/%h expected 0 5/7", first, r0, r1);
    end
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_single_read();
    test_second_tie();
    test_write_read();
    test_stale_complete();
    test_timeout();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer in front of the single-ported, long-latency main memory. It accepts block read/write requests from two requesters (e.g. instruction cache and data cache) and serialises them onto the memory's enable/requestComplete handshake. Round-robin grant keeps either requester from starving. A watchdog aborts accesses the memory never completes.

## Interface
- ADDR_LENGTH, 10, memory address width (log2 of memory LENGTH)
- BLOCK_SIZE, 32, data block width in bits
- TIMEOUT, 255, max cycles in ACCESS before abort; must be greater than the memory delay

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req0, req1  in  1  request level from requester 0 / 1
- we0, we1  in  1  write enable qualifying the request
- addr0, addr1  in  ADDR_LENGTH  request address
- wdata0, wdata1  in  BLOCK_SIZE  write data
- done0, done1  out  1  one-cycle completion pulse to the granted requester
- rdata  out  BLOCK_SIZE  memory read data; valid while a done is high, held until the next completion
- busy  out  1  high in ACCESS and RELEASE
- err  out  1  sticky timeout flag, cleared only by reset
- mem_enable  out  1  to memory enable
- mem_we  out  1  to memory we
- mem_addr  out  ADDR_LENGTH  to memory addr
- mem_wdata  out  BLOCK_SIZE  to memory data_in
- mem_rdata  in  BLOCK_SIZE  from memory data_out
- mem_complete  in  1  from memory requestComplete

## Operation
- Reset values: all outputs 0, state IDLE, last_grant = 1, so requester 0 wins the first tie.
- IDLE: samples req0/req1.
  - If exactly one request is high, grant it.
  - If both are high, grant the requester that is not last_grant.
  - On a grant: latch we/addr/wdata into mem_we/mem_addr/mem_wdata, set mem_enable = 1, update last_grant, go to ACCESS.
  - If neither request is high, stay in IDLE.
- ACCESS: mem_enable is held high and latched outputs are stable.
  - mem_complete is ignored in the first ACCESS cycle, which masks a stale complete from the previous access.
  - From the second ACCESS cycle, mem_complete = 1 causes: rdata <= mem_rdata, mem_enable <= 0, go to RELEASE.
  - rdata is captured for writes too; the memory returns the pre-write contents.
- Watchdog: counts ACCESS cycles. When the count reaches TIMEOUT without a complete:
  - rdata <= 0, err <= 1, mem_enable <= 0, go to RELEASE.
- RELEASE: exactly one cycle. The granted requester's done is high, mem_enable = 0, then go to IDLE.
  - The low cycle guarantees a fresh rising edge of mem_enable for the next access.
- Requester rule: hold req and its qualifiers stable until done is sampled high, then drop req at that same edge.
  - Dropping req before a grant withdraws the request.
  - After a grant, req is not resampled until IDLE.
- Reset mid-operation: return to IDLE next edge. mem_enable drops, the in-flight access is abandoned, no done is issued, and err and last_grant are reset.

## Timing
- Request high in cycle 0 (IDLE) → mem_enable high from cycle 1.
- mem_complete first seen in ACCESS cycle k (k ≥ 2) → done and rdata valid in cycle k+1 (RELEASE) → IDLE in cycle k+2.
- Minimum turnaround: 3 cycles of arbiter overhead plus the memory delay. The next grant's mem_enable rises at cycle k+3 at the earliest.
- done0 and done1 are never high together; each is exactly one cycle wide.
- A request arriving while busy waits. It is granted in the first IDLE cycle and wins if the other requester was served last.
- The watchdog counter is wide enough for TIMEOUT, saturates, and clears on entering ACCESS.

## Test plan
- Single read: memory model LENGTH 1024, delay 8, each location initialised to its index; req0 read addr 10 → one mem_enable rising edge, done0 one cycle, rdata = 10, done1 never asserted.
- Simultaneous: req0 addr 5 and req1 addr 7 both high from reset → requester 0 served first (rdata 5), then requester 1 (rdata 7). A second tie → requester 1 first.
- Write then read: req1 write addr 50, data 0xDEADBEEF → done1 with rdata = 50 (old value). Then req0 read addr 50 → rdata = 0xDEADBEEF.
- Stale complete: hold mem_complete high in the first ACCESS cycle → no early done; completion waits for the real complete.
- Timeout: TIMEOUT 20, memory never completes → done pulse at cycle 22 with rdata = 0, err = 1 and staying high, next request still serviced.
- Reset mid-access: assert reset during ACCESS → mem_enable 0 next cycle, no done, busy 0, err 0. A tie after reset grants requester 0.
